// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, one unpadded 3x3 window out per position (r>=2, c>=2).
// Optional CONV_WIN_SOF_EN adds pix_sof_i to force the accepted pixel to position (0,0).
module conv_window_gen #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  input  logic [DATA_W-1:0] pix_data_i,
`ifdef CONV_WIN_SOF_EN
  input  logic              pix_sof_i,
`endif
  output logic              win_valid_o,
  input  logic              win_ready_i,
  output logic [DATA_W-1:0] win_0,
  output logic [DATA_W-1:0] win_1,
  output logic [DATA_W-1:0] win_2,
  output logic [DATA_W-1:0] win_3,
  output logic [DATA_W-1:0] win_4,
  output logic [DATA_W-1:0] win_5,
  output logic [DATA_W-1:0] win_6,
  output logic [DATA_W-1:0] win_7,
  output logic [DATA_W-1:0] win_8,
  output logic              win_last_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0]              col_p0;
  logic [RW-1:0]              row_p0;
  logic [CW-1:0]              col_eff_p0;
  logic [RW-1:0]              row_eff_p0;
  logic                       sof_p0;
  logic                       accept_p0;
  logic                       emit_p0;
  logic                       last_pos_p0;
  logic signed [DATA_W-1:0]   pix_p0;
  logic signed [DATA_W-1:0]   tap1_p0;
  logic signed [DATA_W-1:0]   tap2_p0;
  logic signed [DATA_W-1:0]   lb1_mem [IMG_W];
  logic signed [DATA_W-1:0]   lb2_mem [IMG_W];
  logic signed [DATA_W-1:0]   win_p1 [9];
  logic                       vld_p1;
  logic                       last_p1;

`ifdef CONV_WIN_SOF_EN
  assign sof_p0 = pix_sof_i;
`else
  assign sof_p0 = 1'b0;
`endif

  // Stage p0: accept, position and line-buffer taps
  assign pix_ready_o = !vld_p1 | win_ready_i;
  assign accept_p0   = pix_valid_i & pix_ready_o;
  assign col_eff_p0  = sof_p0 ? '0 : col_p0;
  assign row_eff_p0  = sof_p0 ? '0 : row_p0;
  assign pix_p0      = pix_data_i;
  // lb1 holds row r-1 and lb2 row r-2, both indexed by column
  assign tap1_p0     = lb1_mem[col_eff_p0];
  assign tap2_p0     = lb2_mem[col_eff_p0];
  assign emit_p0     = accept_p0 & (row_eff_p0 >= RW'(2)) & (col_eff_p0 >= CW'(2));
  assign last_pos_p0 = (row_eff_p0 == ROW_MAX) & (col_eff_p0 == COL_MAX);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (accept_p0) begin
      if (col_eff_p0 == COL_MAX) begin
        col_p0 <= '0;
        row_p0 <= (row_eff_p0 == ROW_MAX) ? '0 : row_eff_p0 + RW'(1);
      end else begin
        col_p0 <= col_eff_p0 + CW'(1);
        row_p0 <= row_eff_p0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept_p0) begin
      lb2_mem[col_eff_p0] <= tap1_p0;
      lb1_mem[col_eff_p0] <= pix_p0;
    end
  end

  // Stage p1: 3x3 window register, doubles as the held output
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) win_p1[i] <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      if (accept_p0) begin
        for (int dy = 0; dy < 3; dy++) begin
          win_p1[3*dy]     <= win_p1[3*dy + 1];
          win_p1[3*dy + 1] <= win_p1[3*dy + 2];
        end
        win_p1[2] <= tap2_p0;
        win_p1[5] <= tap1_p0;
        win_p1[8] <= pix_p0;
        last_p1   <= emit_p0 & last_pos_p0;
      end
      if (emit_p0)
        vld_p1 <= 1'b1;
      else if (win_ready_i)
        vld_p1 <= 1'b0;
    end
  end

  assign win_valid_o = vld_p1;
  assign win_last_o  = last_p1;
  assign win_0 = win_p1[0];
  assign win_1 = win_p1[1];
  assign win_2 = win_p1[2];
  assign win_3 = win_p1[3];
  assign win_4 = win_p1[4];
  assign win_5 = win_p1[5];
  assign win_6 = win_p1[6];
  assign win_7 = win_p1[7];
  assign win_8 = win_p1[8];

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x4 image: table of expected windows plus stall/reset sequences.
module tb_conv_window_gen;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic          pix_valid_i;
  logic          pix_ready_o;
  logic [DW-1:0] pix_data_i;
  logic          pix_sof_r;
  logic          win_valid_o;
  logic          win_ready_i;
  logic [DW-1:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;
  logic          win_last_o;

  always #5 clk_i = ~clk_i;

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .pix_valid_i (pix_valid_i),
    .pix_ready_o (pix_ready_o),
    .pix_data_i  (pix_data_i),
`ifdef CONV_WIN_SOF_EN
    .pix_sof_i   (pix_sof_r),
`endif
    .win_valid_o (win_valid_o),
    .win_ready_i (win_ready_i),
    .win_0       (win_0),
    .win_1       (win_1),
    .win_2       (win_2),
    .win_3       (win_3),
    .win_4       (win_4),
    .win_5       (win_5),
    .win_6       (win_6),
    .win_7       (win_7),
    .win_8       (win_8),
    .win_last_o  (win_last_o)
  );

  typedef struct {
    logic [71:0] win;   // {k8..k0}
    logic        last;
  } vec_t;

  vec_t        base_tab [4];
  logic [72:0] got_q [$];
  logic [72:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [72:0] cur_win();
    return {win_last_o, win_8, win_7, win_6, win_5, win_4, win_3, win_2, win_1, win_0};
  endfunction

  // mode 0: as-is, 1: every pixel +16 (second frame), 2: pixel 0 -> -128, pixel 10 -> 127
  function automatic logic [72:0] xform(input vec_t v, input int mode);
    logic [71:0] w;
    logic [7:0]  b;
    w = v.win;
    for (int i = 0; i < 9; i++) begin
      b = w[8*i +: 8];
      if (mode == 1) b = b + 8'd16;
      if (mode == 2 && b == 8'd0)  b = 8'h80;
      else if (mode == 2 && b == 8'd10) b = 8'h7F;
      w[8*i +: 8] = b;
    end
    return {v.last, w};
  endfunction

  function automatic logic [7:0] pix_val(input int i, input int mode);
    if (mode == 2 && i == 0)  return 8'h80;
    if (mode == 2 && i == 10) return 8'h7F;
    return 8'(i);
  endfunction

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_i)
    if (rst_n && win_valid_o && win_ready_i) got_q.push_back(cur_win());

  task automatic send(input logic [7:0] d, input logic sof);
    bit done;
    done = 0;
    pix_valid_i = 1'b1;
    pix_data_i  = d;
    pix_sof_r   = sof;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk_i);
      if (pix_ready_o) begin
        @(posedge clk_i);
        #1;
        done = 1;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: pixel %0d never accepted", d);
    end
    pix_valid_i = 1'b0;
    pix_sof_r   = 1'b0;
  endtask

  task automatic drain_and_compare(input string name);
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #1;
    check({name, "_count"}, 73'(got_q.size()), 73'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_win%0d", name, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic push_exp(input int mode);
    for (int i = 0; i < 4; i++) exp_q.push_back(xform(base_tab[i], mode));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    base_tab[0] = '{{8'd10, 8'd9,  8'd8,  8'd6, 8'd5,  8'd4, 8'd2, 8'd1, 8'd0}, 1'b0};
    base_tab[1] = '{{8'd11, 8'd10, 8'd9,  8'd7, 8'd6,  8'd5, 8'd3, 8'd2, 8'd1}, 1'b0};
    base_tab[2] = '{{8'd14, 8'd13, 8'd12, 8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4}, 1'b0};
    base_tab[3] = '{{8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5}, 1'b1};

    rst_n       = 1'b0;
    pix_valid_i = 1'b0;
    pix_data_i  = '0;
    pix_sof_r   = 1'b0;
    win_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("reset_outputs", cur_win(), '0);
    check("reset_valid", 73'(win_valid_o), 73'(0));
    check("reset_ready", 73'(pix_ready_o), 73'(1));
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;

    // Test 1: single frame, free-running downstream, with first-window latency
    push_exp(0);
    for (int i = 0; i < 16; i++) begin
      send(pix_val(i, 0), 1'b0);
      if (i == 9 || i == 10) begin
        @(negedge clk_i);
        check($sformatf("t1_valid_after_pix%0d", i), 73'(win_valid_o), 73'(i == 10));
        @(posedge clk_i);
        #1;
      end
    end
    drain_and_compare("t1");

    // Test 2: downstream stalls on the first window for 5 cycles
    win_ready_i = 1'b0;
    push_exp(0);
    for (int i = 0; i < 11; i++) send(pix_val(i, 0), 1'b0);
    pix_valid_i = 1'b1;
    pix_data_i  = 8'd11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check($sformatf("t2_stall_ready%0d", k), 73'(pix_ready_o), 73'(0));
      check($sformatf("t2_stall_valid%0d", k), 73'(win_valid_o), 73'(1));
      check($sformatf("t2_stall_win%0d", k), cur_win(), xform(base_tab[0], 0));
    end
    @(posedge clk_i);
    #1;
    win_ready_i = 1'b1;
    for (int i = 11; i < 16; i++) send(pix_val(i, 0), 1'b0);
    drain_and_compare("t2");

    // Test 3: two frames back-to-back
    push_exp(0);
    push_exp(1);
    for (int i = 0; i < 32; i++) send(pix_val(i, 0), 1'b0);
    drain_and_compare("t3");

    // Test 4: signed extremes pass bit-exact
    push_exp(2);
    for (int i = 0; i < 16; i++) send(pix_val(i, 2), 1'b0);
    drain_and_compare("t4");

    // Test 5: asynchronous reset mid-frame, then a clean frame
    for (int i = 0; i < 7; i++) send(pix_val(i, 0), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_reset_outputs", cur_win(), '0);
    check("t5_reset_valid", 73'(win_valid_o), 73'(0));
    check("t5_reset_ready", 73'(pix_ready_o), 73'(1));
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;
    push_exp(0);
    for (int i = 0; i < 16; i++) send(pix_val(i, 0), 1'b0);
    drain_and_compare("t5");

`ifdef CONV_WIN_SOF_EN
    // Test 6: partial frame abandoned by a start-of-frame pixel
    for (int i = 0; i < 6; i++) send(pix_val(i, 0), 1'b0);
    push_exp(0);
    for (int i = 0; i < 16; i++) send(pix_val(i, 0), i == 0);
    drain_and_compare("t6");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
